// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - shared encodings and helpers for the multiply/divide unit
//
// Purpose: operation and FSM state encodings plus the two's-complement
// magnitude helper used when latching signed operands.
// Ports: none (package).

package muldiv_unit_pkg;

  typedef enum logic [1:0] {
    OP_MULU = 2'b00,
    OP_MULS = 2'b01,
    OP_DIVU = 2'b10,
    OP_DIVS = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // Working width of the magnitude helper; callers zero-extend into it and
  // truncate the result back to their own operand width.
  localparam int MAG_W = 64;

  // Negates v when neg is set. For a zero-extended WIDTH-bit two's-complement
  // value, the low WIDTH bits of the result are its unsigned magnitude
  // (the most-negative value maps to 2^(WIDTH-1), which still fits).
  function automatic logic [MAG_W-1:0] twos_mag(input logic [MAG_W-1:0] v,
                                                input logic             neg);
    return neg ? -v : v;
  endfunction

  function automatic logic op_is_div(input op_e o);
    return (o == OP_DIVU) || (o == OP_DIVS);
  endfunction

  function automatic logic op_is_signed(input op_e o);
    return (o == OP_MULS) || (o == OP_DIVS);
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// rtl/muldiv_datapath.sv - accumulator/shift registers and per-iteration step
//
// Purpose: holds the {hi, lo} working pair and the stored operand, and
// performs one shift-add (multiply) or one restoring-divide step per cycle.
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   load_i     in   capture operands and clear the accumulator
//   step_i     in   perform one iteration
//   div_i      in   operation class captured on load (1 = divide)
//   a_mag_i    in   multiplicand / dividend magnitude
//   b_mag_i    in   multiplier / divisor magnitude
//   hi_o       out  product high half / remainder magnitude
//   lo_o       out  product low half / quotient magnitude

module muldiv_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_mag_i,
  input  logic [WIDTH-1:0] b_mag_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] opnd_q;
  logic             div_q;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_src;
  logic [WIDTH:0]   sub_diff;

  // Multiply: lo holds the multiplier, consumed LSB-first; the carry of the
  // add becomes the new top bit as the pair shifts right.
  // Divide: lo holds the dividend, shifted MSB-first into the partial
  // remainder in hi; quotient bits fill lo from the bottom. The partial
  // remainder stays below the divisor, so the WIDTH+1-bit difference sign
  // is a valid borrow indicator.
  always_comb begin
    add_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    sub_src  = {hi_q, lo_q[WIDTH-1]};
    sub_diff = sub_src - {1'b0, opnd_q};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
    end else if (load_i) begin
      hi_q   <= '0;
      lo_q   <= div_i ? a_mag_i : b_mag_i;
      opnd_q <= div_i ? b_mag_i : a_mag_i;
      div_q  <= div_i;
    end else if (step_i) begin
      if (div_q) begin
        if (!sub_diff[WIDTH]) begin
          hi_q <= sub_diff[WIDTH-1:0];
          lo_q <= {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_q <= sub_src[WIDTH-1:0];
          lo_q <= {lo_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        {hi_q, lo_q} <= {add_sum, lo_q[WIDTH-1:1]};
      end
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative signed/unsigned multiply/divide unit
//
// Purpose: accepts a one-cycle start with operands, iterates WIDTH cycles,
// applies sign correction and flags, and presents registered results with a
// one-cycle done pulse. Divide by zero completes in one cycle.
// Ports:
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   start      in   request pulse, accepted in IDLE or DONE
//   op         in   00 MULU, 01 MULS, 10 DIVU, 11 DIVS
//   a          in   multiplicand / dividend
//   b          in   multiplier / divisor
//   busy       out  high while iterating or fixing up
//   done       out  one-cycle completion pulse
//   result_lo  out  product low half / quotient
//   result_hi  out  product high half / remainder
//   zout       out  mul: full product zero; div: quotient zero
//   cout       out  mul: high half is not the extension of low half
//   dz         out  divide by zero

module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             zout,
  output logic             cout,
  output logic             dz
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  op_e              op_q;
  logic             neg_quo_q;   // quotient / product must be negated
  logic             neg_rem_q;   // remainder must be negated
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] res_lo_q;
  logic [WIDTH-1:0] res_hi_q;
  logic             zout_q;
  logic             cout_q;
  logic             dz_q;

  op_e              in_op;
  logic             in_div;
  logic             in_signed;
  logic             can_accept;
  logic             div_by_zero;
  logic             dp_load;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] dp_hi;
  logic [WIDTH-1:0] dp_lo;

  logic [2*WIDTH-1:0] fix_prod;
  logic [WIDTH-1:0]   fix_lo_d;
  logic [WIDTH-1:0]   fix_hi_d;
  logic               fix_z_d;
  logic               fix_c_d;

  assign in_op       = op_e'(op);
  assign in_div      = op_is_div(in_op);
  assign in_signed   = op_is_signed(in_op);
  assign can_accept  = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign div_by_zero = in_div && (b == '0);
  assign dp_load     = start && can_accept && !div_by_zero;

  assign a_mag = WIDTH'(twos_mag(MAG_W'(a), in_signed & a[WIDTH-1]));
  assign b_mag = WIDTH'(twos_mag(MAG_W'(b), in_signed & b[WIDTH-1]));

  muldiv_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (dp_load),
    .step_i  (state_q == ST_CALC),
    .div_i   (in_div),
    .a_mag_i (a_mag),
    .b_mag_i (b_mag),
    .hi_o    (dp_hi),
    .lo_o    (dp_lo)
  );

  // Sign correction and flags, evaluated from the finished magnitudes and
  // loaded into the output registers on the FIX -> DONE edge.
  always_comb begin
    fix_prod = {dp_hi, dp_lo};
    fix_lo_d = dp_lo;
    fix_hi_d = dp_hi;
    fix_z_d  = 1'b0;
    fix_c_d  = 1'b0;
    if (op_is_div(op_q)) begin
      // Quotient truncates toward zero; remainder follows the dividend.
      // The most-negative / -1 case wraps naturally under negation.
      fix_lo_d = neg_quo_q ? -dp_lo : dp_lo;
      fix_hi_d = neg_rem_q ? -dp_hi : dp_hi;
      fix_z_d  = (fix_lo_d == '0);
    end else begin
      if (neg_quo_q) begin
        fix_prod = -fix_prod;
      end
      fix_lo_d = fix_prod[WIDTH-1:0];
      fix_hi_d = fix_prod[2*WIDTH-1:WIDTH];
      fix_z_d  = (fix_prod == '0);
      // Overflow: the product does not fit back into WIDTH bits.
      if (op_is_signed(op_q)) begin
        fix_c_d = (fix_hi_d != {WIDTH{fix_lo_d[WIDTH-1]}});
      end else begin
        fix_c_d = (fix_hi_d != '0);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= OP_MULU;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      res_lo_q  <= '0;
      res_hi_q  <= '0;
      zout_q    <= 1'b0;
      cout_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            op_q      <= in_op;
            neg_quo_q <= in_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem_q <= in_signed & a[WIDTH-1];
            cnt_q     <= '0;
            dz_q      <= 1'b0;
            if (div_by_zero) begin
              // No iteration: results are defined directly from the inputs.
              state_q  <= ST_DONE;
              done_q   <= 1'b1;
              res_lo_q <= '1;
              res_hi_q <= a;
              zout_q   <= 1'b0;
              cout_q   <= 1'b0;
              dz_q     <= 1'b1;
            end else begin
              state_q <= ST_CALC;
              busy_q  <= 1'b1;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_CALC: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_ITER) begin
            state_q <= ST_FIX;
          end
        end
        ST_FIX: begin
          state_q  <= ST_DONE;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          res_lo_q <= fix_lo_d;
          res_hi_q <= fix_hi_d;
          zout_q   <= fix_z_d;
          cout_q   <= fix_c_d;
          dz_q     <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result_lo = res_lo_q;
  assign result_hi = res_hi_q;
  assign zout      = zout_q;
  assign cout      = cout_q;
  assign dz        = dz_q;

endmodule
